// File: rtl/mux_2_1.sv
// Parameterised 2-to-1 multiplexer with a zero-latency output, an optional
// retimed output stage, and a saturating select-change counter for debug.
module mux_2_1 #(
    parameter int                 WIDTH      = 1,
    parameter int                 REGISTERED = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL  = {WIDTH{1'b0}},
    parameter int                 CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     i0,
    input  logic [WIDTH-1:0]     i1,
    input  logic                 s,
    input  logic                 en,
    output logic [WIDTH-1:0]     y_comb,
    output logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    output logic                 sel_q,
    output logic [CNT_W-1:0]     sw_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] sel_data_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             sel_r;
    logic [CNT_W-1:0] cnt_r;

    // Zero-latency selection, bitwise across the data width.
    always_comb begin
        if (s == 1'b1) begin
            sel_data_s = i1;
        end else begin
            sel_data_s = i0;
        end
    end

    assign y_comb = sel_data_s;

    // Next toggle count: increments on a select change and sticks at its maximum.
    always_comb begin
        cnt_next_s = cnt_r;
        if ((s != sel_r) && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Select tracking runs every edge irrespective of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            sel_r <= s;
            cnt_r <= cnt_next_s;
        end
    end

    assign sel_q  = sel_r;
    assign sw_cnt = cnt_r;

    generate
        if (REGISTERED != 0) begin : g_reg
            logic [WIDTH-1:0] y_r;
            logic             valid_r;

            // Retimed output: load on en, valid flags only the edge that loaded.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_r     <= RESET_VAL;
                    valid_r <= 1'b0;
                end else if (en) begin
                    y_r     <= sel_data_s;
                    valid_r <= 1'b1;
                end else begin
                    y_r     <= y_r;
                    valid_r <= 1'b0;
                end
            end

            assign y         = y_r;
            assign out_valid = valid_r;
        end else begin : g_byp
            // Bypass: output and valid are pure wires, independent of reset.
            assign y         = sel_data_s;
            assign out_valid = en;
        end
    endgenerate

endmodule

// File: tb/tb_mux_2_1.sv
// Self-checking bench for mux_2_1: directed scenarios on four parameterisations
// plus randomized traffic compared against a behavioural reference model.
module tb_mux_2_1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: WIDTH=1, registered
    logic       a_i0, a_i1, a_s, a_en, a_yc, a_y, a_v, a_q;
    logic [7:0] a_cnt;
    // Instance B: WIDTH=8, registered, non-zero reset value
    logic [7:0] b_i0, b_i1, b_yc, b_y, b_cnt;
    logic       b_s, b_en, b_v, b_q;
    // Instance C: WIDTH=8, CNT_W=4
    logic [7:0] c_i0, c_i1, c_yc, c_y;
    logic       c_s, c_en, c_v, c_q;
    logic [3:0] c_cnt;
    // Instance D: WIDTH=8, bypass
    logic [7:0] d_i0, d_i1, d_yc, d_y, d_cnt;
    logic       d_s, d_en, d_v, d_q;

    mux_2_1 #(.WIDTH(1), .REGISTERED(1), .RESET_VAL(1'b0), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .i0(a_i0), .i1(a_i1), .s(a_s), .en(a_en),
        .y_comb(a_yc), .y(a_y), .out_valid(a_v), .sel_q(a_q), .sw_cnt(a_cnt));
    mux_2_1 #(.WIDTH(8), .REGISTERED(1), .RESET_VAL(8'h3C), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .i0(b_i0), .i1(b_i1), .s(b_s), .en(b_en),
        .y_comb(b_yc), .y(b_y), .out_valid(b_v), .sel_q(b_q), .sw_cnt(b_cnt));
    mux_2_1 #(.WIDTH(8), .REGISTERED(1), .RESET_VAL(8'h00), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .i0(c_i0), .i1(c_i1), .s(c_s), .en(c_en),
        .y_comb(c_yc), .y(c_y), .out_valid(c_v), .sel_q(c_q), .sw_cnt(c_cnt));
    mux_2_1 #(.WIDTH(8), .REGISTERED(0), .RESET_VAL(8'h00), .CNT_W(8)) u_d (
        .clk(clk), .rst_n(rst_n), .i0(d_i0), .i1(d_i1), .s(d_s), .en(d_en),
        .y_comb(d_yc), .y(d_y), .out_valid(d_v), .sel_q(d_q), .sw_cnt(d_cnt));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    // Reference model: last loaded value, whether the last edge loaded,
    // last sampled select, and the raw number of select changes seen.
    logic [7:0] m_b_y;
    logic       m_b_v, m_b_sel, m_d_sel;
    int         m_b_chg, m_d_chg;

    // Reference model update at each clock edge / asynchronous reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_b_y   <= 8'h3C;
            m_b_v   <= 1'b0;
            m_b_sel <= 1'b0;
            m_b_chg <= 0;
            m_d_sel <= 1'b0;
            m_d_chg <= 0;
        end else begin
            if (b_en) begin
                m_b_y <= b_s ? b_i1 : b_i0;
                m_b_v <= 1'b1;
            end else begin
                m_b_v <= 1'b0;
            end
            if (b_s != m_b_sel) m_b_chg <= m_b_chg + 1;
            m_b_sel <= b_s;
            if (d_s != m_d_sel) m_d_chg <= m_d_chg + 1;
            m_d_sel <= d_s;
        end
    end

    logic [7:0] tt_exp;
    logic [7:0] exp8;
    logic       prev_s;

    initial begin
        tt_exp = 8'b1101_1000;
        rst_n = 1'b0;
        {a_i0, a_i1, a_s, a_en} = 4'b0000;
        b_i0 = 8'h00; b_i1 = 8'h00; b_s = 1'b0; b_en = 1'b0;
        c_i0 = 8'h00; c_i1 = 8'h00; c_s = 1'b0; c_en = 1'b0;
        d_i0 = 8'h00; d_i1 = 8'h00; d_s = 1'b0; d_en = 1'b0;
        #2;

        // Truth table on the 1-bit instance (held in reset: y_comb must still follow)
        for (int k = 0; k < 8; k++) begin
            a_i0 = k[2]; a_i1 = k[1]; a_s = k[0];
            #1;
            check($sformatf("truth_%0d", k), 32'(a_yc), 32'(tt_exp[k]));
            #9;
        end

        // Reset state
        check("rst_a_y",   32'(a_y),   32'h0);
        check("rst_b_y",   32'(b_y),   32'h3C);
        check("rst_b_v",   32'(b_v),   32'h0);
        check("rst_b_q",   32'(b_q),   32'h0);
        check("rst_b_cnt", 32'(b_cnt), 32'h0);
        d_i0 = 8'h77;
        #1;
        check("rst_d_y",   32'(d_y),   32'h77);

        @(negedge clk) rst_n = 1'b1;

        // Registered latency
        b_en = 1'b1; b_i0 = 8'h5A; b_i1 = 8'hC3; b_s = 1'b0;
        #1;
        check("lat_before", 32'(b_y), 32'h3C);
        @(negedge clk);
        check("lat_y0",  32'(b_y), 32'h5A);
        check("lat_v0",  32'(b_v), 32'h1);
        b_s = 1'b1;
        @(negedge clk);
        check("lat_y1",  32'(b_y), 32'hC3);
        check("lat_v1",  32'(b_v), 32'h1);
        check("lat_q1",  32'(b_q), 32'h1);
        check("lat_cnt", 32'(b_cnt), 32'h1);

        // Enable hold
        b_en = 1'b0; b_i1 = 8'h11; b_s = 1'b1;
        #1;
        check("hold_yc", 32'(b_yc), 32'h11);
        @(negedge clk);
        check("hold_y",  32'(b_y), 32'hC3);
        check("hold_v",  32'(b_v), 32'h0);
        b_s = 1'b0;
        @(negedge clk);
        b_s = 1'b1;
        @(negedge clk);
        check("hold_cnt", 32'(b_cnt), 32'h3);
        check("hold_y2",  32'(b_y), 32'hC3);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("arst_y",   32'(b_y),   32'h3C);
        check("arst_v",   32'(b_v),   32'h0);
        check("arst_q",   32'(b_q),   32'h0);
        check("arst_cnt", 32'(b_cnt), 32'h0);
        b_en = 1'b1; b_s = 1'b0; b_i0 = 8'h5A;
        @(negedge clk);
        check("arst_hold", 32'(b_y), 32'h3C);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_resume_y", 32'(b_y), 32'h5A);
        check("arst_resume_v", 32'(b_v), 32'h1);
        b_en = 1'b0;

        // Counter saturation, CNT_W=4
        c_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            c_s = ~c_s;
            @(negedge clk);
            check($sformatf("sat_%0d", i), 32'(c_cnt), 32'(sat(i + 1, 4)));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("sat_hold_%0d", i), 32'(c_cnt), 32'hF);
        end

        // Bypass mode
        d_en = 1'b1;
        #1 check("byp_v1", 32'(d_v), 32'h1);
        d_en = 1'b0;
        #1 check("byp_v0", 32'(d_v), 32'h0);
        d_i1 = 8'hE4; d_s = 1'b1;
        #1 check("byp_y", 32'(d_y), 32'hE4);
        @(negedge clk);
        check("byp_cnt", 32'(d_cnt), 32'(sat(m_d_chg, 8)));

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            b_i0 = 8'($urandom); b_i1 = 8'($urandom);
            b_s  = 1'($urandom_range(0, 1)); b_en = 1'($urandom_range(0, 1));
            d_i0 = 8'($urandom); d_i1 = 8'($urandom);
            d_s  = 1'($urandom_range(0, 1)); d_en = 1'($urandom_range(0, 1));
            #1;
            exp8 = b_s ? b_i1 : b_i0;
            check("rnd_b_yc", 32'(b_yc), 32'(exp8));
            exp8 = d_s ? d_i1 : d_i0;
            check("rnd_d_y",  32'(d_y),  32'(exp8));
            check("rnd_d_v",  32'(d_v),  32'(d_en));
            @(negedge clk);
            check("rnd_b_y",   32'(b_y),   32'(m_b_y));
            check("rnd_b_v",   32'(b_v),   32'(m_b_v));
            check("rnd_b_q",   32'(b_q),   32'(m_b_sel));
            check("rnd_b_cnt", 32'(b_cnt), 32'(sat(m_b_chg, 8)));
            check("rnd_d_cnt", 32'(d_cnt), 32'(sat(m_d_chg, 8)));
        end

        // Counter stays put when select is held
        prev_s = d_s;
        exp8 = d_cnt;
        repeat (4) @(negedge clk);
        check("still_cnt", 32'(d_cnt), 32'(exp8));
        check("still_q",   32'(d_q),   32'(prev_s));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
